// File: rtl/font_rom_arbiter_if.sv
// Font ROM sharing bus: two requester handshakes, the ROM read port
// and the per-requester glyph-row returns.
interface font_rom_arbiter_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8
);
    logic              req0;
    logic [ADDR_W-1:0] addr0;
    logic              gnt0;
    logic              req1;
    logic [ADDR_W-1:0] addr1;
    logic              gnt1;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_en;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] rdata0;
    logic              rvalid0;
    logic [DATA_W-1:0] rdata1;
    logic              rvalid1;

    modport master (
        output req0, addr0, req1, addr1, rom_data,
        input  gnt0, gnt1, rom_addr, rom_en,
        input  rdata0, rvalid0, rdata1, rvalid1
    );

    modport slave (
        input  req0, addr0, req1, addr1, rom_data,
        output gnt0, gnt1, rom_addr, rom_en,
        output rdata0, rvalid0, rdata1, rvalid1
    );
endinterface

// File: rtl/font_rom_arbiter.sv
// Shares one font ROM between the label (priority) and digit requesters;
// a burst counter bounds how long the digit renderer can be starved.
module font_rom_arbiter #(
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 8,
    parameter int ROM_LAT   = 1,
    parameter int MAX_BURST = 4
) (
    input logic               reloj,
    input logic               resetM,
    font_rom_arbiter_if.slave rom_bus
);
    localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

    logic [3:0]        burst_cnt;
    logic              at_limit;
    logic              pick1_forced;
    logic              pick0;
    logic              pick1_idle;
    logic              any_gnt;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] ret_data;
    logic [ROM_LAT:0]  dly_vld;
    logic [ROM_LAT:0]  dly_tag;
    logic              ret_vld;
    logic              ret_tag;

    assign at_limit = (burst_cnt == BURST_MAX);

    // Mutually exclusive selectors so the decoder below is truly one-hot
    assign pick1_forced = rom_bus.req0 & rom_bus.req1 & at_limit;
    assign pick0        = rom_bus.req0 & ~pick1_forced;
    assign pick1_idle   = rom_bus.req1 & ~rom_bus.req0;

    always_comb begin
        rom_bus.gnt0 = 1'b0;
        rom_bus.gnt1 = 1'b0;
        if (resetM) begin
            unique case (1'b1)
                pick1_forced: rom_bus.gnt1 = 1'b1;
                pick0:        rom_bus.gnt0 = 1'b1;
                pick1_idle:   rom_bus.gnt1 = 1'b1;
                default:      ;
            endcase
        end
    end

    assign any_gnt  = rom_bus.gnt0 | rom_bus.gnt1;
    assign win_addr = rom_bus.gnt1 ? rom_bus.addr1
                                   : rom_bus.addr0;

    always_ff @(posedge reloj or negedge resetM) begin
        if (!resetM) begin
            burst_cnt <= '0;
        end else if (rom_bus.gnt1 || !rom_bus.req1) begin
            burst_cnt <= '0;
        end else if (rom_bus.gnt0 && !at_limit) begin
            burst_cnt <= burst_cnt + 4'd1;
        end
    end

    always_ff @(posedge reloj or negedge resetM) begin
        if (!resetM) begin
            rom_bus.rom_addr <= '0;
            rom_bus.rom_en   <= 1'b0;
        end else begin
            rom_bus.rom_en <= any_gnt;
            if (any_gnt) begin
                rom_bus.rom_addr <= win_addr;
            end
        end
    end

    // Stage k holds the grant issued k+1 cycles ago; the last stage
    // lines up with rom_data for that grant.
    always_ff @(posedge reloj or negedge resetM) begin
        if (!resetM) begin
            dly_vld <= '0;
            dly_tag <= '0;
        end else begin
            dly_vld <= {dly_vld[ROM_LAT-1:0], any_gnt};
            dly_tag <= {dly_tag[ROM_LAT-1:0], rom_bus.gnt1};
        end
    end

    assign ret_vld  = dly_vld[ROM_LAT];
    assign ret_tag  = dly_tag[ROM_LAT];
    assign ret_data = rom_bus.rom_data;

    always_ff @(posedge reloj or negedge resetM) begin
        if (!resetM) begin
            rom_bus.rdata0  <= '0;
            rom_bus.rdata1  <= '0;
            rom_bus.rvalid0 <= 1'b0;
            rom_bus.rvalid1 <= 1'b0;
        end else begin
            rom_bus.rvalid0 <= ret_vld & ~ret_tag;
            rom_bus.rvalid1 <= ret_vld & ret_tag;
            if (ret_vld && !ret_tag) begin
                rom_bus.rdata0 <= ret_data;
            end
            if (ret_vld && ret_tag) begin
                rom_bus.rdata1 <= ret_data;
            end
        end
    end
endmodule

// File: tb/tb_font_rom_arbiter.sv
// Directed bench: arbiter A (ROM_LAT=1, MAX_BURST=4) and
// arbiter B (ROM_LAT=2, MAX_BURST=1), each with a ROM model.
module tb_font_rom_arbiter;
    localparam int AW = 9;
    localparam int DW = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   passes;

    logic          hv [32];
    logic          ht [32];
    logic [AW-1:0] ha [32];
    logic [DW-1:0] exp_a0, exp_a1, exp_b0, exp_b1;
    logic [DW-1:0] b_s1;

    font_rom_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) a_if ();
    font_rom_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b_if ();

    font_rom_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(1), .MAX_BURST(4)
    ) u_a (
        .reloj(clk), .resetM(rst_n), .rom_bus(a_if.slave)
    );

    font_rom_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(2), .MAX_BURST(1)
    ) u_b (
        .reloj(clk), .resetM(rst_n), .rom_bus(b_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
        logic [DW-1:0] m;
        m = a[7:0] * 8'd29;
        return m ^ {a[8], 7'h35};
    endfunction

    always @(posedge clk) begin
        if (a_if.rom_en) a_if.rom_data <= rom_fn(a_if.rom_addr);
    end

    always @(posedge clk) begin
        if (b_if.rom_en) b_s1 <= rom_fn(b_if.rom_addr);
        b_if.rom_data <= b_s1;
    end

    task automatic clear_hist();
        for (int i = 0; i < 32; i++) begin
            hv[i] = 1'b0;
            ht[i] = 1'b0;
            ha[i] = '0;
        end
    endtask

    task automatic test_reset();
        a_if.req0 = 1'b1;
        a_if.addr0 = 9'h1AB;
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if ({a_if.gnt0, a_if.gnt1, a_if.rom_en, a_if.rom_addr,
             a_if.rdata0, a_if.rdata1, a_if.rvalid0, a_if.rvalid1} !== '0)
            $display("FAIL reset_a: got g%b%b en%b a%h d%h %h v%b%b want 0",
                     a_if.gnt0, a_if.gnt1, a_if.rom_en, a_if.rom_addr,
                     a_if.rdata0, a_if.rdata1, a_if.rvalid0, a_if.rvalid1);
        else passes++;
        checks++;
        if ({b_if.gnt0, b_if.gnt1, b_if.rom_en, b_if.rom_addr,
             b_if.rdata0, b_if.rdata1, b_if.rvalid0, b_if.rvalid1} !== '0)
            $display("FAIL reset_b: got en%b a%h d%h %h v%b%b want 0",
                     b_if.rom_en, b_if.rom_addr, b_if.rdata0,
                     b_if.rdata1, b_if.rvalid0, b_if.rvalid1);
        else passes++;
        checks++;
        if (u_a.burst_cnt !== 4'd0)
            $display("FAIL reset_cnt: got %0d want 0", u_a.burst_cnt);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        a_if.req0 = 1'b0;
    endtask

    task automatic test_single_read();
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            a_if.req0 = (k == 0);
            a_if.addr0 = 9'h0C5;
            #1;
            checks++;
            if ({a_if.gnt0, a_if.gnt1} !== {(k == 0), 1'b0})
                $display("FAIL single gnt k=%0d: got %b%b want %b0",
                         k, a_if.gnt0, a_if.gnt1, (k == 0));
            else passes++;
            checks++;
            if (a_if.rom_en !== (k == 1) ||
                (k == 1 && a_if.rom_addr !== 9'h0C5))
                $display("FAIL single issue k=%0d: got en%b a%h want en%b a0c5",
                         k, a_if.rom_en, a_if.rom_addr, (k == 1));
            else passes++;
            checks++;
            if ({a_if.rvalid0, a_if.rvalid1} !== {(k == 3), 1'b0})
                $display("FAIL single rvalid k=%0d: got %b%b want %b0",
                         k, a_if.rvalid0, a_if.rvalid1, (k == 3));
            else passes++;
            if (k >= 3) begin
                checks++;
                if (a_if.rdata0 !== rom_fn(9'h0C5))
                    $display("FAIL single rdata0 k=%0d: got %h want %h",
                             k, a_if.rdata0, rom_fn(9'h0C5));
                else passes++;
            end
        end
        exp_a0 = rom_fn(9'h0C5);
    endtask

    task automatic test_contention();
        int n0, n1;
        logic e0, e1, v0, v1;
        n0 = 0;
        n1 = 0;
        clear_hist();
        for (int k = 0; k < 24; k++) begin
            @(posedge clk); #1;
            a_if.req0 = (k < 20);
            a_if.req1 = (k < 20);
            a_if.addr0 = 9'(9'h020 + n0);
            a_if.addr1 = 9'(9'h140 + n1);
            #1;
            e1 = (k < 20) && (k % 5 == 4);
            e0 = (k < 20) && !e1;
            checks++;
            if ({a_if.gnt0, a_if.gnt1} !== {e0, e1})
                $display("FAIL contention gnt k=%0d: got %b%b want %b%b",
                         k, a_if.gnt0, a_if.gnt1, e0, e1);
            else passes++;
            hv[k] = e0 | e1;
            ht[k] = e1;
            ha[k] = e1 ? a_if.addr1 : a_if.addr0;
            if (e0) n0++;
            if (e1) n1++;
            v0 = 1'b0;
            v1 = 1'b0;
            if (k >= 3) begin
                if (hv[k-3] && ht[k-3]) begin
                    v1 = 1'b1;
                    exp_a1 = rom_fn(ha[k-3]);
                end else if (hv[k-3]) begin
                    v0 = 1'b1;
                    exp_a0 = rom_fn(ha[k-3]);
                end
            end
            checks++;
            if ({a_if.rvalid0, a_if.rvalid1, a_if.rdata0, a_if.rdata1}
                !== {v0, v1, exp_a0, exp_a1})
                $display("FAIL contention ret k=%0d: got %b%b %h %h want %b%b %h %h",
                         k, a_if.rvalid0, a_if.rvalid1, a_if.rdata0,
                         a_if.rdata1, v0, v1, exp_a0, exp_a1);
            else passes++;
        end
    endtask

    task automatic test_back_to_back();
        logic v1;
        clear_hist();
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            a_if.req0 = 1'b0;
            a_if.req1 = (k < 16);
            a_if.addr1 = 9'(9'h150 + k);
            #1;
            checks++;
            if ({a_if.gnt0, a_if.gnt1} !== {1'b0, (k < 16)})
                $display("FAIL b2b gnt k=%0d: got %b%b want 0%b",
                         k, a_if.gnt0, a_if.gnt1, (k < 16));
            else passes++;
            hv[k] = (k < 16);
            ha[k] = a_if.addr1;
            v1 = 1'b0;
            if (k >= 3) begin
                if (hv[k-3]) begin
                    v1 = 1'b1;
                    exp_a1 = rom_fn(ha[k-3]);
                end
            end
            checks++;
            if ({a_if.rvalid0, a_if.rvalid1, a_if.rdata0, a_if.rdata1}
                !== {1'b0, v1, exp_a0, exp_a1})
                $display("FAIL b2b ret k=%0d: got %b%b %h %h want 0%b %h %h",
                         k, a_if.rvalid0, a_if.rvalid1, a_if.rdata0,
                         a_if.rdata1, v1, exp_a0, exp_a1);
            else passes++;
        end
    endtask

    task automatic test_counter_clear();
        int n0;
        logic e0, e1, v0, v1;
        n0 = 0;
        clear_hist();
        for (int k = 0; k < 13; k++) begin
            @(posedge clk); #1;
            a_if.req0 = (k < 9);
            a_if.req1 = (k < 9) && (k != 3);
            a_if.addr0 = 9'(9'h060 + n0);
            a_if.addr1 = 9'h170;
            #1;
            if (k == 3 || k == 4) begin
                checks++;
                if (u_a.burst_cnt !== ((k == 3) ? 4'd3 : 4'd0))
                    $display("FAIL clear cnt k=%0d: got %0d want %0d",
                             k, u_a.burst_cnt, (k == 3) ? 3 : 0);
                else passes++;
            end
            e1 = (k == 8);
            e0 = (k < 8);
            checks++;
            if ({a_if.gnt0, a_if.gnt1} !== {e0, e1})
                $display("FAIL clear gnt k=%0d: got %b%b want %b%b",
                         k, a_if.gnt0, a_if.gnt1, e0, e1);
            else passes++;
            hv[k] = e0 | e1;
            ht[k] = e1;
            ha[k] = e1 ? a_if.addr1 : a_if.addr0;
            if (e0) n0++;
            v0 = 1'b0;
            v1 = 1'b0;
            if (k >= 3) begin
                if (hv[k-3] && ht[k-3]) begin
                    v1 = 1'b1;
                    exp_a1 = rom_fn(ha[k-3]);
                end else if (hv[k-3]) begin
                    v0 = 1'b1;
                    exp_a0 = rom_fn(ha[k-3]);
                end
            end
            checks++;
            if ({a_if.rvalid0, a_if.rvalid1, a_if.rdata0, a_if.rdata1}
                !== {v0, v1, exp_a0, exp_a1})
                $display("FAIL clear ret k=%0d: got %b%b %h %h want %b%b %h %h",
                         k, a_if.rvalid0, a_if.rvalid1, a_if.rdata0,
                         a_if.rdata1, v0, v1, exp_a0, exp_a1);
            else passes++;
        end
    endtask

    task automatic test_reset_midflight();
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            a_if.req0 = (k < 3);
            a_if.addr0 = 9'(9'h0E0 + k);
            #1;
        end
        checks++;
        if ({a_if.rom_en, a_if.rvalid0, a_if.rdata0}
            !== {2'b11, rom_fn(9'h0E0)})
            $display("FAIL midflight pre: got en%b v%b d%h want en1 v1 d%h",
                     a_if.rom_en, a_if.rvalid0, a_if.rdata0,
                     rom_fn(9'h0E0));
        else passes++;
        #1;
        a_if.req0 = 1'b1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a_if.gnt0, a_if.gnt1, a_if.rom_en, a_if.rom_addr,
             a_if.rdata0, a_if.rdata1, a_if.rvalid0, a_if.rvalid1,
             u_a.burst_cnt} !== '0)
            $display("FAIL midflight async: got g%b%b en%b a%h d%h %h v%b%b",
                     a_if.gnt0, a_if.gnt1, a_if.rom_en, a_if.rom_addr,
                     a_if.rdata0, a_if.rdata1, a_if.rvalid0, a_if.rvalid1);
        else passes++;
        exp_a0 = '0;
        exp_a1 = '0;
        @(negedge clk);
        a_if.req0 = 1'b0;
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #2;
            checks++;
            if ({a_if.rvalid0, a_if.rvalid1, a_if.rom_en} !== 3'b000)
                $display("FAIL midflight post k=%0d: got v%b%b en%b want 000",
                         k, a_if.rvalid0, a_if.rvalid1, a_if.rom_en);
            else passes++;
        end
    endtask

    task automatic test_rom_lat2();
        int n0, n1;
        logic e0, e1, v0, v1;
        n0 = 0;
        n1 = 0;
        clear_hist();
        for (int k = 0; k < 13; k++) begin
            @(posedge clk); #1;
            b_if.req0 = (k < 8);
            b_if.req1 = (k < 8);
            b_if.addr0 = 9'(9'h030 + n0);
            b_if.addr1 = 9'(9'h180 + n1);
            #1;
            e0 = (k < 8) && (k % 2 == 0);
            e1 = (k < 8) && (k % 2 == 1);
            checks++;
            if ({b_if.gnt0, b_if.gnt1} !== {e0, e1})
                $display("FAIL lat2 gnt k=%0d: got %b%b want %b%b",
                         k, b_if.gnt0, b_if.gnt1, e0, e1);
            else passes++;
            hv[k] = e0 | e1;
            ht[k] = e1;
            ha[k] = e1 ? b_if.addr1 : b_if.addr0;
            if (e0) n0++;
            if (e1) n1++;
            v0 = 1'b0;
            v1 = 1'b0;
            if (k >= 4) begin
                if (hv[k-4] && ht[k-4]) begin
                    v1 = 1'b1;
                    exp_b1 = rom_fn(ha[k-4]);
                end else if (hv[k-4]) begin
                    v0 = 1'b1;
                    exp_b0 = rom_fn(ha[k-4]);
                end
            end
            checks++;
            if ({b_if.rvalid0, b_if.rvalid1, b_if.rdata0, b_if.rdata1}
                !== {v0, v1, exp_b0, exp_b1})
                $display("FAIL lat2 ret k=%0d: got %b%b %h %h want %b%b %h %h",
                         k, b_if.rvalid0, b_if.rvalid1, b_if.rdata0,
                         b_if.rdata1, v0, v1, exp_b0, exp_b1);
            else passes++;
        end
    endtask

    initial begin
        checks = 0;
        passes = 0;
        rst_n = 1'b0;
        exp_a0 = '0;
        exp_a1 = '0;
        exp_b0 = '0;
        exp_b1 = '0;
        a_if.req0 = 1'b0;
        a_if.req1 = 1'b0;
        a_if.addr0 = '0;
        a_if.addr1 = '0;
        b_if.req0 = 1'b0;
        b_if.req1 = 1'b0;
        b_if.addr0 = '0;
        b_if.addr1 = '0;
        test_reset();
        test_single_read();
        test_contention();
        test_back_to_back();
        test_counter_clear();
        test_reset_midflight();
        test_rom_lat2();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
